// File: rtl/t0_pkg.sv
// Shared definitions for the T0 bus decoder.
//   - t0_state_e : decoder synchronisation state (UNSYNC / SYNC)
//   - DEF_W      : default bus/data width
//   - DEF_STRIDE : default address increment implied by an INC cycle
//   - CNT_W      : width of the saturating INC statistics counter
package t0_pkg;

    localparam int DEF_W      = 8;
    localparam int DEF_STRIDE = 1;
    localparam int CNT_W      = 16;

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } t0_state_e;

endpackage

// File: rtl/t0_sat_cnt.sv
// Saturating event counter used for the INC statistics.
//   ck    : clock (rising edge)
//   rstn  : asynchronous active-low reset, clears count
//   inc   : count one event this cycle
//   clr   : clear the count; a same-cycle inc leaves the count at 1
//   count : current count, sticks at all-ones
module t0_sat_cnt
    import t0_pkg::*;
(
    input  logic             ck,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Counter register: clear has priority but a coincident event is still counted.
    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            count_r <= CNT_ZERO;
        end else if (clr) begin
            count_r <= inc ? CNT_ONE : CNT_ZERO;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/t0_bus_decoder.sv
// T0 bus decoder. Reconstructs the value carried on a T0-encoded bus: on
// a normal cycle the bus lines carry the value itself, on an INC cycle the
// encoder freezes the lines and the value is the previous one + STRIDE.
//   ck, rstn   : clock and asynchronous active-low reset
//   bus_data   : T0-encoded bus lines (frozen during INC cycles)
//   bus_inc    : INC line, value = previous decoded value + STRIDE
//   bus_valid  : qualifies bus_data/bus_inc
//   resync     : drop the reference value and return to UNSYNC
//   clr_stats  : clear sticky flags and the INC counter
//   dout       : decoded value (registered)
//   dout_valid : dout updated this cycle (registered)
//   sync_err   : sticky, INC seen without a reference value
//   frz_err    : sticky, bus lines moved during an INC cycle
//   inc_cnt    : saturating count of accepted INC cycles
// All outputs come straight from flops; no input reaches an output
// combinationally.
module t0_bus_decoder
    import t0_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int STRIDE = DEF_STRIDE
) (
    input  logic             ck,
    input  logic             rstn,
    input  logic [W-1:0]     bus_data,
    input  logic             bus_inc,
    input  logic             bus_valid,
    input  logic             resync,
    input  logic             clr_stats,
    output logic [W-1:0]     dout,
    output logic             dout_valid,
    output logic             sync_err,
    output logic             frz_err,
    output logic [CNT_W-1:0] inc_cnt
);

    localparam logic [W-1:0] STEP = W'(STRIDE);

    t0_state_e    state_r;
    logic [W-1:0] dout_r;
    logic [W-1:0] last_raw_r;
    logic         dout_valid_r;
    logic         sync_err_r;
    logic         frz_err_r;

    logic         xfer_s;
    logic         sync_set_s;
    logic         frz_set_s;
    logic         inc_acc_s;

    // Event decode; resync cancels any transfer so it also masks its events.
    always_comb begin
        xfer_s     = bus_valid && !resync;
        sync_set_s = 1'b0;
        frz_set_s  = 1'b0;
        inc_acc_s  = 1'b0;
        if (xfer_s && bus_inc) begin
            if (state_r == UNSYNC) begin
                sync_set_s = 1'b1;
            end else begin
                inc_acc_s = 1'b1;
                frz_set_s = (bus_data != last_raw_r);
            end
        end else begin
            sync_set_s = 1'b0;
        end
    end

    // Decoder FSM: state, decoded value, reference raw value and valid strobe.
    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            state_r      <= UNSYNC;
            dout_r       <= {W{1'b0}};
            last_raw_r   <= {W{1'b0}};
            dout_valid_r <= 1'b0;
        end else if (resync) begin
            state_r      <= UNSYNC;
            dout_valid_r <= 1'b0;
        end else if (!bus_valid) begin
            dout_valid_r <= 1'b0;
        end else begin
            case (state_r)
                UNSYNC: begin
                    if (!bus_inc) begin
                        dout_r       <= bus_data;
                        last_raw_r   <= bus_data;
                        dout_valid_r <= 1'b1;
                        state_r      <= SYNC;
                    end else begin
                        // No reference to increment from: drop the cycle.
                        dout_valid_r <= 1'b0;
                    end
                end
                SYNC: begin
                    if (!bus_inc) begin
                        dout_r       <= bus_data;
                        last_raw_r   <= bus_data;
                        dout_valid_r <= 1'b1;
                    end else begin
                        // Frozen lines are ignored; wrap is modulo 2^W.
                        dout_r       <= dout_r + STEP;
                        dout_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= UNSYNC;
                    dout_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags: a same-cycle set beats clr_stats.
    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            sync_err_r <= 1'b0;
            frz_err_r  <= 1'b0;
        end else begin
            sync_err_r <= sync_set_s || (sync_err_r && !clr_stats);
            frz_err_r  <= frz_set_s  || (frz_err_r  && !clr_stats);
        end
    end

    t0_sat_cnt u_inc_cnt (
        .ck    (ck),
        .rstn  (rstn),
        .inc   (inc_acc_s),
        .clr   (clr_stats),
        .count (inc_cnt)
    );

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign sync_err   = sync_err_r;
    assign frz_err    = frz_err_r;

endmodule

// File: tb/tb_t0_bus_decoder.sv
// Self-checking bench for t0_bus_decoder (default W=8, STRIDE=1).
module tb_t0_bus_decoder;

    logic        ck;
    logic        rstn;
    logic [7:0]  bus_data;
    logic        bus_inc;
    logic        bus_valid;
    logic        resync;
    logic        clr_stats;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        sync_err;
    logic        frz_err;
    logic [15:0] inc_cnt;

    typedef struct {
        logic [7:0]  dout;
        logic        dv;
        logic        serr;
        logic        ferr;
        logic [15:0] cnt;
        logic        chk;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic        m_sync;
    logic [7:0]  m_dout;
    logic [7:0]  m_raw;
    logic        m_dv;
    logic        m_serr;
    logic        m_ferr;
    logic [15:0] m_cnt;

    t0_bus_decoder dut (
        .ck         (ck),
        .rstn       (rstn),
        .bus_data   (bus_data),
        .bus_inc    (bus_inc),
        .bus_valid  (bus_valid),
        .resync     (resync),
        .clr_stats  (clr_stats),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sync_err   (sync_err),
        .frz_err    (frz_err),
        .inc_cnt    (inc_cnt)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic model_reset();
        m_sync = 1'b0; m_dout = 8'h00; m_raw = 8'h00; m_dv = 1'b0;
        m_serr = 1'b0; m_ferr = 1'b0; m_cnt = 16'h0000;
        exp_q.delete();
    endtask

    // One bus cycle: drive, push model expectation, clock, pop and compare.
    task automatic cyc(input logic v, input logic i, input logic [7:0] d,
                       input logic rs, input logic cl, input logic chk);
        exp_t e;
        exp_t g;
        logic sset, fset, iacc;
        bus_valid = v; bus_inc = i; bus_data = d; resync = rs; clr_stats = cl;
        sset = 1'b0; fset = 1'b0; iacc = 1'b0;
        if (rs) begin
            m_sync = 1'b0; m_dv = 1'b0;
        end else if (!v) begin
            m_dv = 1'b0;
        end else if (!m_sync) begin
            if (!i) begin
                m_dout = d; m_raw = d; m_dv = 1'b1; m_sync = 1'b1;
            end else begin
                m_dv = 1'b0; sset = 1'b1;
            end
        end else if (!i) begin
            m_dout = d; m_raw = d; m_dv = 1'b1;
        end else begin
            m_dout = m_dout + 8'h01; m_dv = 1'b1; iacc = 1'b1;
            fset = (d != m_raw);
        end
        if (cl) begin
            m_serr = sset; m_ferr = fset; m_cnt = iacc ? 16'h0001 : 16'h0000;
        end else begin
            m_serr = m_serr | sset; m_ferr = m_ferr | fset;
            if (iacc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
        end
        e.dout = m_dout; e.dv = m_dv; e.serr = m_serr; e.ferr = m_ferr;
        e.cnt = m_cnt; e.chk = chk;
        exp_q.push_back(e);
        @(posedge ck);
        #1;
        g = exp_q.pop_front();
        if (g.chk) begin
            total += 5;
            if (dout !== g.dout) begin bad++; $display("FAIL sb_dout got=%h exp=%h t=%0t", dout, g.dout, $time); end
            if (dout_valid !== g.dv) begin bad++; $display("FAIL sb_dout_valid got=%b exp=%b t=%0t", dout_valid, g.dv, $time); end
            if (sync_err !== g.serr) begin bad++; $display("FAIL sb_sync_err got=%b exp=%b t=%0t", sync_err, g.serr, $time); end
            if (frz_err !== g.ferr) begin bad++; $display("FAIL sb_frz_err got=%b exp=%b t=%0t", frz_err, g.ferr, $time); end
            if (inc_cnt !== g.cnt) begin bad++; $display("FAIL sb_inc_cnt got=%h exp=%h t=%0t", inc_cnt, g.cnt, $time); end
        end
    endtask

    task automatic check_zero(input string tag);
        total++;
        if ({dout, dout_valid, sync_err, frz_err, inc_cnt} !== 27'd0) begin
            bad++;
            $display("FAIL %s got dout=%h dv=%b se=%b fe=%b cnt=%h exp all zero",
                     tag, dout, dout_valid, sync_err, frz_err, inc_cnt);
        end
    endtask

    task automatic do_reset();
        @(negedge ck);
        rstn = 1'b0;
        bus_valid = 1'b0; bus_inc = 1'b0; bus_data = 8'h00;
        resync = 1'b0; clr_stats = 1'b0;
        model_reset();
        @(negedge ck);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus_valid = 1'b0; bus_inc = 1'b0; bus_data = 8'h00;
        resync = 1'b0; clr_stats = 1'b0;
        model_reset();
        #3;
        check_zero("reset_state");
        @(negedge ck);
        rstn = 1'b1;
    endtask

    task automatic test_inc_basic();
        cyc(1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
        total++;
        if (dout !== 8'h13 || dout_valid !== 1'b1 || inc_cnt !== 16'd3 || sync_err !== 1'b0 || frz_err !== 1'b0) begin
            bad++;
            $display("FAIL inc_basic got dout=%h dv=%b cnt=%h se=%b fe=%b exp 13/1/0003/0/0",
                     dout, dout_valid, inc_cnt, sync_err, frz_err);
        end
    endtask

    task automatic test_unsync_inc();
        do_reset();
        cyc(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        total++;
        if (dout_valid !== 1'b0 || sync_err !== 1'b1 || dout !== 8'h00) begin
            bad++;
            $display("FAIL unsync_inc got dv=%b se=%b dout=%h exp 0/1/00", dout_valid, sync_err, dout);
        end
        cyc(1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1);
        total++;
        if (dout !== 8'h21 || dout_valid !== 1'b1) begin
            bad++;
            $display("FAIL unsync_resume got dout=%h dv=%b exp 21/1", dout, dout_valid);
        end
    endtask

    task automatic test_wrap_frz();
        cyc(1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        total++;
        if (dout !== 8'h00 || frz_err !== 1'b0 || sync_err !== 1'b0) begin
            bad++;
            $display("FAIL wrap got dout=%h fe=%b se=%b exp 00/0/0", dout, frz_err, sync_err);
        end
        cyc(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        total++;
        if (dout !== 8'h01 || frz_err !== 1'b1) begin
            bad++;
            $display("FAIL frz got dout=%h fe=%b exp 01/1", dout, frz_err);
        end
    endtask

    task automatic test_idle();
        cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h66, 1'b0, 1'b0, 1'b1);
        total++;
        if (dout_valid !== 1'b0 || dout !== 8'h01) begin
            bad++;
            $display("FAIL idle_hold got dv=%b dout=%h exp 0/01", dout_valid, dout);
        end
    endtask

    task automatic test_resync();
        cyc(1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1);
        total++;
        if (dout_valid !== 1'b0 || dout !== 8'h01 || sync_err !== 1'b0) begin
            bad++;
            $display("FAIL resync got dv=%b dout=%h se=%b exp 0/01/0", dout_valid, dout, sync_err);
        end
        cyc(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        total++;
        if (sync_err !== 1'b1 || dout_valid !== 1'b0) begin
            bad++;
            $display("FAIL resync_inc got se=%b dv=%b exp 1/0", sync_err, dout_valid);
        end
        // clear coinciding with a new sync error: the set wins
        cyc(1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
        total++;
        if (sync_err !== 1'b1) begin
            bad++;
            $display("FAIL clr_vs_set got se=%b exp 1", sync_err);
        end
    endtask

    task automatic test_saturate();
        cyc(1'b1, 1'b0, 8'h40, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 65534; k++) cyc(1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        total++;
        if (inc_cnt !== 16'hFFFE) begin
            bad++;
            $display("FAIL preload got cnt=%h exp FFFE", inc_cnt);
        end
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b1);
        total++;
        if (inc_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL saturate got cnt=%h exp FFFF", inc_cnt);
        end
        cyc(1'b1, 1'b1, 8'h40, 1'b0, 1'b1, 1'b1);
        total++;
        if (inc_cnt !== 16'h0001) begin
            bad++;
            $display("FAIL clr_with_inc got cnt=%h exp 0001", inc_cnt);
        end
    endtask

    task automatic test_mid_reset();
        cyc(1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b1);
        @(negedge ck);
        #2;
        rstn = 1'b0;
        #1;
        check_zero("mid_reset_async");
        bus_valid = 1'b0; bus_inc = 1'b0; resync = 1'b0; clr_stats = 1'b0;
        model_reset();
        @(negedge ck);
        rstn = 1'b1;
        // reference value was discarded: an INC now is a sync error
        cyc(1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 8'h9C, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 8'h9C, 1'b0, 1'b0, 1'b1);
        total++;
        if (dout !== 8'h9D || sync_err !== 1'b1) begin
            bad++;
            $display("FAIL post_reset got dout=%h se=%b exp 9D/1", dout, sync_err);
        end
    endtask

    initial begin
        test_reset();
        test_inc_basic();
        test_unsync_inc();
        test_wrap_frz();
        test_idle();
        test_resync();
        test_saturate();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/t0_bus_decoder.md
T0_BUS_DECODER -- requirements
Module: t0_bus_decoder

Interface
REQ-001 Parameter W, default 8: data width of the bus and the output.
REQ-002 Parameter STRIDE, default 1: address increment implied by an INC cycle.
REQ-003 Port ck, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rstn, input, 1: asynchronous, active-low reset.
REQ-005 Port bus_data, input, W: T0-encoded bus lines; frozen by the encoder during INC cycles.
REQ-006 Port bus_inc, input, 1: T0 INC line; 1 = value is previous decoded value + STRIDE.
REQ-007 Port bus_valid, input, 1: qualifies bus_data/bus_inc this cycle.
REQ-008 Port resync, input, 1: forces the decoder back to UNSYNC.
REQ-009 Port clr_stats, input, 1: clears sticky error flags and the INC counter.
REQ-010 Port dout, output, W: decoded value, registered.
REQ-011 Port dout_valid, output, 1: dout updated this cycle, registered.
REQ-012 Port sync_err, output, 1: sticky; INC received with no reference value.
REQ-013 Port frz_err, output, 1: sticky; bus_data changed during an INC cycle.
REQ-014 Port inc_cnt, output, 16: saturating count of accepted INC cycles (transitions saved).

Function
REQ-015 The FSM SHALL have two states, UNSYNC (no reference value) and SYNC.
REQ-016 Latency SHALL be one cycle: an accepted transfer at edge n appears on dout/dout_valid after edge n.
REQ-017 bus_valid=0 SHALL give dout_valid=0 next cycle; dout, last_raw, state and counters hold.
REQ-018 UNSYNC, valid, inc=0: dout<=bus_data, last_raw<=bus_data, dout_valid<=1, go to SYNC.
REQ-019 UNSYNC, valid, inc=1: dout_valid<=0, dout holds, sync_err<=1, stay UNSYNC.
REQ-020 SYNC, valid, inc=0: dout<=bus_data, last_raw<=bus_data, dout_valid<=1.
REQ-021 SYNC, valid, inc=1: dout<=(dout+STRIDE) mod 2^W, dout_valid<=1, last_raw holds, inc_cnt increments.
REQ-022 SYNC, valid, inc=1, bus_data!=last_raw: decode per REQ-021 (bus_data ignored), frz_err<=1.
REQ-023 Wrap-around: dout=2^W-1 with INC, STRIDE=1, SHALL yield 0 with no flag.
REQ-024 inc_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-025 resync=1 SHALL move state to UNSYNC and force dout_valid<=0, overriding any transfer that cycle; dout holds.
REQ-026 clr_stats=1 SHALL clear sync_err, frz_err and inc_cnt; a same-cycle set/increment event wins (flag=1, inc_cnt=1).
REQ-027 No combinational path SHALL exist from any input to any output.

Reset
REQ-028 rstn=0 SHALL immediately force state=UNSYNC, dout=0, last_raw=0, dout_valid=0, sync_err=0, frz_err=0, inc_cnt=0.
REQ-029 Reset asserted mid-stream SHALL discard the reference value; the first post-reset transfer must be inc=0.

Structure
REQ-030 Package t0_pkg SHALL hold the state enum (UNSYNC, SYNC), default W and STRIDE, and the counter width constant (16).
REQ-031 The saturating counter SHALL be the single sub-module t0_sat_cnt (inc, clr, count; clr+inc gives 1).
REQ-032 Block size: 120-400 lines of RTL; no latches; all registers on ck with async rstn.

Verification
REQ-033 Reset, then valid inc=0 data=8'h10, then 3x valid inc=1 data=8'h10 -> dout 10,11,12,13, dout_valid=1 each cycle, inc_cnt=3, no flags.
REQ-034 After reset, valid inc=1 data=8'h55 -> dout_valid=0, sync_err=1, dout=0; then inc=0 data=8'h20 -> dout=8'h20, state SYNC.
REQ-035 SYNC dout=8'hFF, valid inc=1 -> dout=8'h00; then inc=1 with data!=last_raw -> dout=8'h01, frz_err=1.
REQ-036 Preload inc_cnt=16'hFFFE, 3 INC cycles -> inc_cnt=16'hFFFF stays; clr_stats with a same-cycle INC -> inc_cnt=1.
REQ-037 resync with valid inc=0 data=8'h33 -> dout_valid=0, dout unchanged; next inc=1 -> sync_err=1.
REQ-038 rstn pulsed low mid-stream between edges -> all outputs 0 immediately, before the next ck edge.
